// File: rtl/vita36_pkg.sv
// Shared definitions for the 36-bit VITA packet mux/demux pair:
// word-field bit positions, the framing state enum and a header re-tag helper.
package vita36_pkg;

    localparam int SOF_BIT     = 32;
    localparam int EOF_BIT     = 33;
    localparam int OCC_MSB     = 35;
    localparam int OCC_LSB     = 34;
    localparam int HAS_SID_BIT = 28;
    localparam int LEN_MSB     = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SID  = 2'd2,
        FWD  = 2'd3
    } vita_state_e;

    // Header of an untagged packet once a SID word follows it: has_sid set,
    // one extra line, and EOF moved onto the SID word.
    function automatic logic [35:0] tag_header(input logic [35:0] hdr);
        tag_header = {hdr[OCC_MSB:OCC_LSB], 1'b0, 1'b1, hdr[31:29], 1'b1,
                      hdr[27:16], hdr[LEN_MSB:0] + 16'd1};
    endfunction

endpackage

// File: rtl/vita_packet_mux36_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1,
// wrapping to channel 0. The grant history lives in the parent.
module rr_arbiter #(
    parameter int NUMCHAN = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUMCHAN-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    int cand_s;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant  = {IDX_W{1'b0}};
        valid  = 1'b0;
        cand_s = 0;
        for (int i = NUMCHAN; i >= 1; i--) begin
            cand_s = int'(last_grant) + i;
            if (cand_s >= NUMCHAN) begin
                cand_s = cand_s - NUMCHAN;
            end else begin
                cand_s = cand_s;
            end
            grant = req[cand_s] ? IDX_W'(cand_s) : grant;
            valid = valid | req[cand_s];
        end
    end

endmodule

// File: rtl/vita_packet_mux36.sv
// Merges NUMCHAN VITA-36 streams into one, whole packets at a time, inserting a
// Stream ID word (SID_BASE+channel) after the header of any packet lacking one.
module vita_packet_mux36
    import vita36_pkg::*;
#(
    parameter int          NUMCHAN  = 2,
    parameter logic [31:0] SID_BASE = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [36*NUMCHAN-1:0] in_data,
    input  logic [NUMCHAN-1:0]    in_src_rdy,
    output logic [NUMCHAN-1:0]    in_dst_rdy,
    output logic [35:0]           out_data,
    output logic                  out_src_rdy,
    input  logic                  out_dst_rdy
);

    localparam int IDX_W = (NUMCHAN > 1) ? $clog2(NUMCHAN) : 1;
    localparam logic [IDX_W-1:0] LAST_CHAN = IDX_W'(NUMCHAN - 1);

    vita_state_e      state_r, state_s;
    logic [IDX_W-1:0] chan_r, chan_s;
    logic [IDX_W-1:0] last_grant_r, last_grant_s;
    logic             eof_r, eof_s;

    logic [35:0]        chan_word_s [NUMCHAN];
    logic [NUMCHAN-1:0] sof_s;
    logic [NUMCHAN-1:0] req_s;
    logic [35:0]        cur_word_s;
    logic               cur_valid_s;
    logic               xfer_s;
    logic [IDX_W-1:0]   arb_grant_s;
    logic               arb_valid_s;
    logic [35:0]        out_data_s;
    logic               out_src_rdy_s;
    logic [NUMCHAN-1:0] dst_rdy_s;

    // Split the flat input bus into per-channel words and arbitration requests.
    always_comb begin
        for (int i = 0; i < NUMCHAN; i++) begin
            chan_word_s[i] = in_data[36*i +: 36];
            sof_s[i]       = in_data[36*i + SOF_BIT];
            req_s[i]       = in_src_rdy[i] & in_data[36*i + SOF_BIT];
        end
    end

    assign cur_word_s  = chan_word_s[chan_r];
    assign cur_valid_s = in_src_rdy[chan_r];
    assign xfer_s      = cur_valid_s & out_dst_rdy;

    rr_arbiter #(
        .NUMCHAN (NUMCHAN),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .valid      (arb_valid_s)
    );

    // Framing state, selected channel, fairness pointer and deferred EOF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            chan_r       <= {IDX_W{1'b0}};
            last_grant_r <= LAST_CHAN;
            eof_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            chan_r       <= chan_s;
            last_grant_r <= last_grant_s;
            eof_r        <= eof_s;
        end
    end

    // Next-state, output mux and per-channel ready generation.
    always_comb begin
        state_s       = state_r;
        chan_s        = chan_r;
        last_grant_s  = last_grant_r;
        eof_s         = eof_r;
        out_data_s    = cur_word_s;
        out_src_rdy_s = 1'b0;
        dst_rdy_s     = {NUMCHAN{1'b0}};
        case (state_r)
            IDLE: begin
                // Words without SOF cannot start a packet, so they are drained.
                dst_rdy_s = ~sof_s;
                if (arb_valid_s) begin
                    state_s = HDR;
                    chan_s  = arb_grant_s;
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
                out_src_rdy_s     = cur_valid_s;
                dst_rdy_s[chan_r] = out_dst_rdy;
                if (cur_word_s[HAS_SID_BIT]) begin
                    out_data_s = cur_word_s;
                    if (xfer_s && cur_word_s[EOF_BIT]) begin
                        state_s      = IDLE;
                        last_grant_s = chan_r;
                    end else if (xfer_s) begin
                        state_s = FWD;
                    end else begin
                        state_s = HDR;
                    end
                end else begin
                    out_data_s = tag_header(cur_word_s);
                    if (xfer_s) begin
                        eof_s   = cur_word_s[EOF_BIT];
                        state_s = SID;
                    end else begin
                        state_s = HDR;
                    end
                end
            end
            SID: begin
                out_data_s    = {2'b00, eof_r, 1'b0, SID_BASE + 32'(chan_r)};
                out_src_rdy_s = 1'b1;
                if (out_dst_rdy && eof_r) begin
                    state_s      = IDLE;
                    last_grant_s = chan_r;
                end else if (out_dst_rdy) begin
                    state_s = FWD;
                end else begin
                    state_s = SID;
                end
            end
            FWD: begin
                out_src_rdy_s     = cur_valid_s;
                dst_rdy_s[chan_r] = out_dst_rdy;
                if (xfer_s && cur_word_s[EOF_BIT]) begin
                    state_s      = IDLE;
                    last_grant_s = chan_r;
                end else begin
                    state_s = FWD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign out_data    = out_data_s;
    assign out_src_rdy = out_src_rdy_s & ~rst;
    assign in_dst_rdy  = dst_rdy_s & {NUMCHAN{~rst}};

endmodule
